// File: rtl/pixel_l1_event_buffer_pkg.sv
// Shared constants for the pixel L1 event buffer.
// A FIFO entry is {tag[L1CW-1:0], E1A, data[35:0]}. With the default 8-bit tag
// the entry is 45 bits wide. The field offsets below do not depend on L1CW,
// because the tag is always the top field of the entry.
package pixel_l1_event_buffer_pkg;

  localparam int DATA_W         = 36;            // 29-bit TDC word + 7-bit Hamming, undecoded
  localparam int L1CW_DEF       = 8;             // default L1A counter width
  localparam int ENTRY_DATA_LSB = 0;
  localparam int ENTRY_E1A_BIT  = DATA_W;        // 36
  localparam int ENTRY_TAG_LSB  = DATA_W + 1;    // 37

  function automatic int entryWidth(input int l1cw);
    return l1cw + 1 + DATA_W;
  endfunction

endpackage

// File: rtl/l1_event_fifo.sv
// Generic synchronous FIFO.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   push/pushData : write request. It is accepted when the FIFO is not full, or
//                   when it is full and a pop is accepted on the same edge.
//   pop      : read request. It is ignored while the FIFO is empty.
//   popData  : head entry, read combinationally from the storage array.
//   full, empty : status flags derived from the pointers.
// The pointers carry one extra wrap bit, so full and empty are told apart by
// the MSB alone.
module l1_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 45
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] pushData,
  output logic [W-1:0] popData,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wrPtr, rdPtr;
  logic [W-1:0] mem [DEPTH];
  logic         doPush, doPop;

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop   = pop & ~empty;
  // When the FIFO is full, a pop on the same edge frees the slot this push will use.
  assign doPush  = push & (~full | doPop);
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // The storage array is not reset. Stale contents are masked by the empty flag.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/pixel_l1_event_buffer.sv
// Pixel L1 event buffer: this module aligns each L1A trigger with the circular
// buffer's delayed hit flag and data, tags it with the L1A count, and queues the
// hit triggers for column readout.
// Ports:
//   clk, reset  : 40 MHz bunch clock and asynchronous active-high reset
//   L1A         : trigger pulse, sampled at edge N
//   hitIn/E1AIn : hit flag and hit-memory error flag, sampled at edge N+1
//   dataIn      : 36-bit TDC and Hamming word, sampled at edge N+2
//   rdEn        : readout pop request
//   dout        : FIFO head {tag, E1A, data}, forced to 0 while the FIFO is empty
//   doutValid   : high when the FIFO is not empty
//   full        : high when the FIFO holds DEPTH entries
//   overflowCnt : saturating count of hit triggers dropped on a full FIFO
module pixel_l1_event_buffer
  import pixel_l1_event_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int L1CW  = L1CW_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         L1A,
  input  logic                         hitIn,
  input  logic                         E1AIn,
  input  logic [DATA_W-1:0]            dataIn,
  input  logic                         rdEn,
  output logic [entryWidth(L1CW)-1:0]  dout,
  output logic                         doutValid,
  output logic                         full,
  output logic [7:0]                   overflowCnt
);

  localparam int EW = entryWidth(L1CW);

  logic [L1CW-1:0] l1Count;
  logic [L1CW-1:0] tag0, tag1;
  logic            e1a1;
  // vldPipe[0]: an L1A was seen at the last edge.
  // vldPipe[1]: that trigger carried a hit, so a write is due on the next edge.
  logic [1:0]      vldPipe;
  logic [EW-1:0]   entry, head;
  logic            empty, wrDue, drop;

  assign wrDue = vldPipe[1];
  // When full, doutValid is high, so rdEn alone tells us whether a pop frees the slot.
  assign drop  = wrDue & full & ~rdEn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l1Count     <= '0;
      vldPipe     <= '0;
      tag0        <= '0;
      tag1        <= '0;
      e1a1        <= 1'b0;
      overflowCnt <= '0;
    end else begin
      if (L1A) l1Count <= l1Count + 1'b1;
      vldPipe[0] <= L1A;
      tag0       <= l1Count;
      // Triggers without a hit are discarded here and never reach the FIFO.
      vldPipe[1] <= vldPipe[0] & hitIn;
      tag1       <= tag0;
      e1a1       <= E1AIn;
      if (drop && overflowCnt != 8'hFF) overflowCnt <= overflowCnt + 8'd1;
    end
  end

  always_comb begin
    entry                                 = '0;
    entry[ENTRY_TAG_LSB +: L1CW]          = tag1;
    entry[ENTRY_E1A_BIT]                  = e1a1;
    entry[ENTRY_DATA_LSB +: DATA_W]       = dataIn;
  end

  l1_event_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wrDue),
    .pop      (rdEn),
    .pushData (entry),
    .popData  (head),
    .full     (full),
    .empty    (empty)
  );

  assign doutValid = ~empty;
  assign dout      = empty ? '0 : head;

endmodule

// File: tb/tb_pixel_l1_event_buffer.sv
module tb_pixel_l1_event_buffer;

  logic        clk = 1'b0;
  logic        reset, L1A, hitIn, E1AIn, rdEn;
  logic [35:0] dataIn;
  logic [44:0] dout;
  logic        doutValid, full;
  logic [7:0]  overflowCnt;

  always #5 clk = ~clk;

  pixel_l1_event_buffer #(.DEPTH(8), .L1CW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .L1A         (L1A),
    .hitIn       (hitIn),
    .E1AIn       (E1AIn),
    .dataIn      (dataIn),
    .rdEn        (rdEn),
    .dout        (dout),
    .doutValid   (doutValid),
    .full        (full),
    .overflowCnt (overflowCnt)
  );

  int          nTests = 0;
  int          nFail  = 0;
  logic [44:0] q[$];      // expected FIFO contents, head first
  logic [7:0]  tagCnt;    // expected L1A counter
  logic [7:0]  expOvf;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Drive one cycle of inputs. The task returns at the next falling edge.
  task automatic tick(input logic l1a, input logic hit, input logic e1a,
                      input logic [35:0] data, input logic rd);
    L1A = l1a; hitIn = hit; E1AIn = e1a; dataIn = data; rdEn = rd;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick(0, 0, 0, '0, 0);
    reset = 1'b0;
    tagCnt = '0;
    expOvf = '0;
    q.delete();
  endtask

  // Send one hit trigger in the serial N, N+1, N+2 pattern. rd is driven on the
  // data edge. If a pop is due it takes effect first, and the push is then
  // accepted when there is room.
  task automatic trigHit(input logic e1a, input logic [35:0] data, input logic rd);
    logic [44:0] e;
    e = {tagCnt, e1a, data};
    tick(1, 0, 0, '0, 0);
    tagCnt = tagCnt + 8'd1;
    tick(0, 1, e1a, '0, 0);
    if (rd && q.size() > 0) begin
      chk("head_before_pop", dout, q[0]);
      void'(q.pop_front());
    end
    if (q.size() < 8) q.push_back(e);
    else if (expOvf != 8'hFF) expOvf = expOvf + 8'd1;
    tick(0, 0, 0, data, rd);
  endtask

  task automatic popChk(input string name);
    if (q.size() == 0) begin
      nTests++; nFail++;
      $error("FAIL %s: scoreboard empty, observed doutValid %0b", name, doutValid);
    end else begin
      chk({name, "_valid"}, doutValid, 1'b1);
      chk({name, "_dout"}, dout, q.pop_front());
    end
    tick(0, 0, 0, '0, 1);
  endtask

  initial begin
    reset = 1'b1; L1A = 0; hitIn = 0; E1AIn = 0; dataIn = '0; rdEn = 0;
    tagCnt = '0; expOvf = '0;
    @(negedge clk);
    tick(0, 0, 0, '0, 0);
    chk("rst_valid", doutValid, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_dout", dout, 45'd0);
    chk("rst_ovf", overflowCnt, 8'd0);
    reset = 1'b0;
    tick(0, 0, 0, '0, 0);

    // Single trigger: the entry appears after the data edge.
    tick(1, 0, 0, '0, 0);
    tick(0, 1, 0, '0, 0);
    chk("single_not_yet", doutValid, 1'b0);
    q.push_back({8'h00, 1'b0, 36'h0ABCDE123});
    tagCnt = 8'd1;
    tick(0, 0, 0, 36'h0ABCDE123, 0);
    chk("single_full", full, 1'b0);
    popChk("single");
    chk("single_empty", doutValid, 1'b0);

    // Three back-to-back L1As with hits 1,0,1.
    doReset();
    tick(1, 0, 0, '0, 0);                        // trigger 0
    tick(1, 1, 0, '0, 0);                        // trigger 1, hit for trigger 0
    tick(1, 0, 0, 36'h111111111, 0);             // trigger 2, no hit for 1, data for 0
    tick(0, 1, 1, 36'h222222222, 0);             // hit for 2, data for 1 is ignored
    tick(0, 0, 0, 36'h333333333, 0);             // data for trigger 2
    q.push_back({8'd0, 1'b0, 36'h111111111});
    q.push_back({8'd2, 1'b1, 36'h333333333});
    tagCnt = 8'd3;
    popChk("b2b_0");
    popChk("b2b_1");
    chk("b2b_empty", doutValid, 1'b0);
    trigHit(0, 36'h000000444, 0);                // the next tag must be 3
    popChk("b2b_tag3");

    // Fill to 8 entries, then one more hit is dropped.
    doReset();
    for (int i = 0; i < 8; i++) trigHit(i[0], 36'(i + 16), 0);
    chk("fill_full", full, 1'b1);
    chk("fill_ovf0", overflowCnt, 8'd0);
    trigHit(1, 36'h0DEAD0009, 0);
    chk("ovf_full", full, 1'b1);
    chk("ovf_cnt", overflowCnt, expOvf);
    // Full FIFO with rdEn on the due write edge: pop and push both happen.
    trigHit(0, 36'h0BEEF000A, 1);
    chk("fullrw_full", full, 1'b1);
    chk("fullrw_ovf", overflowCnt, 8'd1);
    for (int i = 0; i < 8; i++) popChk("drain");
    chk("drain_empty", doutValid, 1'b0);
    chk("drain_notfull", full, 1'b0);

    // rdEn while empty is ignored.
    tick(0, 0, 0, '0, 1);
    tick(0, 0, 0, '0, 1);
    chk("rd_empty_valid", doutValid, 1'b0);
    trigHit(0, 36'h0CAFE0001, 0);
    popChk("after_rd_empty");

    // Push with pop on an empty FIFO: the push is kept.
    trigHit(1, 36'h0F00D0002, 1);
    popChk("push_pop_empty");
    chk("push_pop_empty_done", doutValid, 1'b0);

    // 256 L1As without hits wrap the counter, so the next tag is 0.
    doReset();
    for (int i = 0; i < 256; i++) tick(1, 0, 0, '0, 0);
    tagCnt = 8'h00;
    trigHit(0, 36'h012345678, 0);
    popChk("wrap_tag");
    chk("wrap_empty", doutValid, 1'b0);

    // Overflow counter saturates at 255: 270 hits, 8 stored, 262 dropped.
    doReset();
    for (int i = 0; i < 270; i++) tick(1, 1, 0, 36'(i), 0);
    tick(0, 1, 0, 36'd270, 0);
    tick(0, 0, 0, 36'd271, 0);
    chk("sat_ovf", overflowCnt, 8'hFF);
    chk("sat_full", full, 1'b1);
    chk("sat_head", dout, {8'd0, 1'b0, 36'd2});

    // Reset one cycle after an L1A that carries a hit.
    doReset();
    tick(1, 0, 0, '0, 0);
    reset = 1'b1;
    tick(0, 1, 0, '0, 0);
    reset = 1'b0;
    tick(0, 0, 0, 36'h0AAAA5555, 0);
    tick(0, 0, 0, 36'h055550AAA, 0);
    chk("midrst_valid", doutValid, 1'b0);
    chk("midrst_full", full, 1'b0);
    chk("midrst_dout", dout, 45'd0);
    chk("midrst_ovf", overflowCnt, 8'd0);
    tagCnt = '0; q.delete();
    trigHit(0, 36'h000000777, 0);
    popChk("midrst_tag0");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
